// File: rtl/axi4_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi4_slave_mem
// Brief    : AXI4 slave with an internal word-addressed RAM. It serves one
//            INCR write or read burst at a time.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH          = 1024
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [7:0]                        s00_axi_awlen,
    input  logic [2:0]                        s00_axi_awsize,
    input  logic [1:0]                        s00_axi_awburst,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wlast,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_bid,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [7:0]                        s00_axi_arlen,
    input  logic [2:0]                        s00_axi_arsize,
    input  logic [1:0]                        s00_axi_arburst,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rlast,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);

    localparam int c_strb_w   = C_S_AXI_DATA_WIDTH / 8;
    localparam int c_addr_lsb = $clog2(c_strb_w);
    localparam int c_idx_w    = $clog2(MEM_DEPTH);
    localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wdata = 2'd1;
    localparam logic [1:0] c_st_wresp = 2'd2;
    localparam logic [1:0] c_st_rdata = 2'd3;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [1:0]                    r_state;
    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_bid;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                    r_rresp;
    logic                          r_rlast;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_rid;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_id;
    logic [c_idx_w-1:0]            r_idx;
    logic [7:0]                    r_len;
    logic [7:0]                    r_beat;
    logic                          r_burst_ok;
    logic                          r_err;

    logic               w_aw_hs;
    logic               w_ar_hs;
    logic               w_w_hs;
    logic               w_r_hs;
    logic               w_b_hs;
    logic               w_aw_ok;
    logic               w_ar_ok;
    logic [c_idx_w-1:0] w_aw_idx;
    logic [c_idx_w-1:0] w_ar_idx;
    logic               w_last_beat;
    logic               w_wlast_bad;
    logic               w_mem_we;
    logic               w_unused_bits;

    // A pending write always wins the IDLE slot over a pending read.
    assign s00_axi_awready = r_awready;
    assign s00_axi_arready = r_awready & ~s00_axi_awvalid;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_bid     = r_bid;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rlast   = r_rlast;
    assign s00_axi_rid     = r_rid;

    assign w_aw_hs     = s00_axi_awvalid & r_awready;
    assign w_ar_hs     = s00_axi_arvalid & s00_axi_arready;
    assign w_w_hs      = s00_axi_wvalid & r_wready;
    assign w_r_hs      = r_rvalid & s00_axi_rready;
    assign w_b_hs      = r_bvalid & s00_axi_bready;
    assign w_aw_ok     = (s00_axi_awburst == 2'b01);
    assign w_ar_ok     = (s00_axi_arburst == 2'b01);
    assign w_aw_idx    = s00_axi_awaddr[c_addr_lsb +: c_idx_w];
    assign w_ar_idx    = s00_axi_araddr[c_addr_lsb +: c_idx_w];
    assign w_last_beat = (r_beat == r_len);
    assign w_wlast_bad = (s00_axi_wlast != w_last_beat);
    assign w_mem_we    = s00_axi_aresetn & w_w_hs & r_burst_ok;

    // Size fields and address bits outside the word index carry no meaning here.
    assign w_unused_bits = ^{s00_axi_awsize, s00_axi_arsize, s00_axi_awaddr, s00_axi_araddr};

    always_ff @(posedge s00_axi_aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (s00_axi_wstrb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_state    <= c_st_idle;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_resp_okay;
            r_bid      <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= c_resp_okay;
            r_rlast    <= 1'b0;
            r_rid      <= '0;
            r_id       <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_burst_ok <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_aw_hs) begin
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_id       <= s00_axi_awid;
                        r_idx      <= w_aw_idx;
                        r_len      <= s00_axi_awlen;
                        r_burst_ok <= w_aw_ok;
                        r_beat     <= '0;
                        r_err      <= 1'b0;
                        r_state    <= c_st_wdata;
                    end else if (w_ar_hs) begin
                        // The first beat is fetched here so rvalid can rise right away.
                        r_awready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rid      <= s00_axi_arid;
                        r_rdata    <= w_ar_ok ? r_mem[w_ar_idx] : '0;
                        r_rresp    <= w_ar_ok ? c_resp_okay : c_resp_slverr;
                        r_rlast    <= (s00_axi_arlen == 8'd0);
                        r_idx      <= w_ar_idx + c_idx_one;
                        r_len      <= s00_axi_arlen;
                        r_burst_ok <= w_ar_ok;
                        r_beat     <= '0;
                        r_state    <= c_st_rdata;
                    end else begin
                        r_awready  <= 1'b1;
                    end
                end
                c_st_wdata: begin
                    if (w_w_hs) begin
                        r_idx  <= r_idx + c_idx_one;
                        r_beat <= r_beat + 8'd1;
                        if (w_wlast_bad) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= (!r_burst_ok || r_err || w_wlast_bad) ?
                                        c_resp_slverr : c_resp_okay;
                            r_state  <= c_st_wresp;
                        end
                    end
                end
                c_st_wresp: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= c_st_idle;
                    end
                end
                c_st_rdata: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_awready <= 1'b1;
                            r_state   <= c_st_idle;
                        end else begin
                            r_rdata <= r_burst_ok ? r_mem[r_idx] : '0;
                            r_idx   <= r_idx + c_idx_one;
                            r_beat  <= r_beat + 8'd1;
                            r_rlast <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_slave_mem
// Brief    : Self-checking bench for axi4_slave_mem against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_slave_mem;

    localparam int c_depth = 1024;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi4_slave_mem #(
        .C_S_AXI_ID_WIDTH  (1),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .MEM_DEPTH         (c_depth)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(aresetn),
        .s00_axi_awid   (awid),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awlen  (awlen),
        .s00_axi_awsize (awsize),
        .s00_axi_awburst(awburst),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wlast  (wlast),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bid    (bid),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_arid   (arid),
        .s00_axi_araddr (araddr),
        .s00_axi_arlen  (arlen),
        .s00_axi_arsize (arsize),
        .s00_axi_arburst(arburst),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rid    (rid),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rlast  (rlast),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  id;
    } rbeat_t;

    logic [31:0] model_mem [c_depth];
    rbeat_t      r_exp [$];
    logic [2:0]  b_exp [$];
    logic [31:0] got_q [$];
    logic [31:0] wbeat_data [256];
    logic [3:0]  wbeat_strb [256];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every R/B handshake against the model queues, and
    // output stability whenever the master stalls a valid response.
    rbeat_t     cmp_e;
    rbeat_t     prev_r;
    logic [2:0] prev_b;
    logic [2:0] cmp_b;
    logic       prev_rstall = 1'b0;
    logic       prev_bstall = 1'b0;

    always @(negedge clk) begin
        if (!aresetn) begin
            prev_rstall = 1'b0;
            prev_bstall = 1'b0;
        end else begin
            if (prev_rstall)
                check("r_hold", {rvalid, rdata, rresp, rlast, rid}, {1'b1, prev_r});
            if (prev_bstall)
                check("b_hold", {bvalid, bid, bresp}, {1'b1, prev_b});
            if (rvalid && rready) begin
                if (r_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL r_unexpected: got beat %h expected none", rdata);
                end else begin
                    cmp_e = r_exp.pop_front();
                    check("r_beat", {rdata, rresp, rlast, rid}, cmp_e);
                end
                got_q.push_back(rdata);
            end
            if (bvalid && bready) begin
                if (b_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected: got resp %h expected none", bresp);
                end else begin
                    cmp_b = b_exp.pop_front();
                    check("b_resp", {bid, bresp}, cmp_b);
                end
            end
            prev_rstall = rvalid && !rready;
            prev_r      = {rdata, rresp, rlast, rid};
            prev_bstall = bvalid && !bready;
            prev_b      = {bid, bresp};
        end
    end

    function automatic logic pick_rready(input int mode, input int cyc);
        if (mode == 0) return 1'($urandom_range(0, 1));
        if (mode == 1) return 1'(cyc % 2);
        return 1'b1;
    endfunction

    // bad_last: -1 correct wlast, -2 wlast missing on final beat, k>=0 extra wlast on beat k
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input int bad_last, input int bdelay, input bit also_ar);
        int  base;
        int  k;
        bit  ok;
        bit  err;
        ok   = (burst == 2'b01);
        err  = (bad_last != -1);
        base = int'((addr >> 2) % c_depth);
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst; awid = id; awsize = 3'd2;
        if (also_ar) arvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!awready && k < 50) begin @(negedge clk); k++; end
        check("aw_accept", 64'(awready), 64'd1);
        if (also_ar) check("ar_blocked_by_aw", 64'(arready), 64'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; awaddr = $urandom;
        @(negedge clk);
        check("wready_after_aw", 64'(wready), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(posedge clk); #1; end
            wvalid = 1'b1; wdata = wbeat_data[i]; wstrb = wbeat_strb[i];
            wlast  = ((i == int'(len)) && bad_last != -2) || (i == bad_last);
            k = 0;
            @(negedge clk);
            while (!wready && k < 50) begin @(negedge clk); k++; end
            check("w_accept", 64'(wready), 64'd1);
            if (ok) begin
                for (int b = 0; b < 4; b++)
                    if (wbeat_strb[i][b]) model_mem[(base + i) % c_depth][8*b +: 8] = wbeat_data[i][8*b +: 8];
            end
        end
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0; bready = (bdelay == 0);
        b_exp.push_back({id, (ok && !err) ? 2'b00 : 2'b10});
        @(negedge clk);
        check("bvalid_after_last_w", 64'(bvalid), 64'd1);
        if (bdelay > 0) begin
            repeat (bdelay) @(posedge clk);
            #1 bready = 1'b1;
            @(negedge clk);
        end
        k = 0;
        while (!bvalid && k < 50) begin @(negedge clk); k++; end
        check("b_wait", 64'(bvalid), 64'd1);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("idle_after_b", {bvalid, awready}, 64'b01);
    endtask

    // mode: 0 random rready, 1 toggle every cycle, 2 always ready
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id, input int mode, input bit ar_pre);
        int     base;
        int     k;
        int     cyc;
        bit     ok;
        rbeat_t e;
        ok   = (burst == 2'b01);
        base = int'((addr >> 2) % c_depth);
        got_q.delete();
        for (int i = 0; i <= int'(len); i++) begin
            e.data = ok ? model_mem[(base + i) % c_depth] : 32'h0;
            e.resp = ok ? 2'b00 : 2'b10;
            e.last = (i == int'(len));
            e.id   = id;
            r_exp.push_back(e);
        end
        if (!ar_pre) begin
            @(posedge clk); #1;
            arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd2;
            @(negedge clk);
        end
        k = 0;
        while (!arready && k < 50) begin @(negedge clk); k++; end
        check("ar_accept", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; araddr = $urandom; rready = pick_rready(mode, 0);
        @(negedge clk);
        check("rvalid_after_ar", 64'(rvalid), 64'd1);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (got_q.size() >= int'(len) + 1) break;
            rready = pick_rready(mode, cyc);
        end while (cyc < 2000);
        rready = 1'b0;
        check("r_beat_count", 64'(got_q.size()), 64'(int'(len) + 1));
        if (got_q.size() != int'(len) + 1) r_exp.delete();
        @(negedge clk);
        check("idle_after_r", {rvalid, awready}, 64'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          bad;
        int          r;

        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid}, 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
        @(posedge clk); #1 aresetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", {awready, arready}, 64'b11);

        // Prefill the whole RAM so every later read has a defined model value.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wbeat_data[i] = $urandom; wbeat_strb[i] = 4'hF; end
            do_write(32'(blk * 1024), 8'd255, 2'b01, 1'b0, -1, 0, 1'b0);
        end

        // Basic 4-beat write and readback.
        for (int i = 0; i < 4; i++) begin wbeat_data[i] = 32'hA0 + 32'(i); wbeat_strb[i] = 4'hF; end
        do_write(32'h10, 8'd3, 2'b01, 1'b1, -1, 0, 1'b0);
        do_read(32'h10, 8'd3, 2'b01, 1'b1, 2, 1'b0);
        check("t1_beat0", 64'(got_q[0]), 64'h0000_00A0);
        check("t1_beat3", 64'(got_q[3]), 64'h0000_00A3);

        // Byte strobes.
        wbeat_data[0] = 32'hFFFF_FFFF; wbeat_strb[0] = 4'hF;
        do_write(32'h40, 8'd0, 2'b01, 1'b0, -1, 0, 1'b0);
        wbeat_data[0] = 32'h1122_3344; wbeat_strb[0] = 4'b0101;
        do_write(32'h40, 8'd0, 2'b01, 1'b0, -1, 0, 1'b0);
        do_read(32'h40, 8'd0, 2'b01, 1'b0, 2, 1'b0);
        check("strobe_merge", 64'(got_q[0]), 64'hFF22_FF44);

        // Stalled read and delayed B handshake.
        do_read(32'h100, 8'd7, 2'b01, 1'b1, 1, 1'b0);
        for (int i = 0; i < 2; i++) begin wbeat_data[i] = $urandom; wbeat_strb[i] = 4'hF; end
        do_write(32'h180, 8'd1, 2'b01, 1'b1, -1, 5, 1'b0);

        // Simultaneous AW and AR: write first, read then sees the new data.
        wbeat_data[0] = 32'h5555_AAAA; wbeat_data[1] = 32'h1234_5678;
        wbeat_strb[0] = 4'hF; wbeat_strb[1] = 4'hF;
        araddr = 32'h80; arlen = 8'd1; arburst = 2'b01; arid = 1'b1; arsize = 3'd2;
        do_write(32'h80, 8'd1, 2'b01, 1'b0, -1, 0, 1'b1);
        do_read(32'h80, 8'd1, 2'b01, 1'b1, 2, 1'b1);
        check("aw_before_ar_data", 64'(got_q[0]), 64'h5555_AAAA);

        // Index wrap at the top of the RAM.
        wbeat_data[0] = 32'hCAFE_0000; wbeat_data[1] = 32'hCAFE_0001;
        wbeat_strb[0] = 4'hF; wbeat_strb[1] = 4'hF;
        do_write(32'hFFC, 8'd1, 2'b01, 1'b0, -1, 0, 1'b0);
        do_read(32'h0, 8'd0, 2'b01, 1'b0, 2, 1'b0);
        check("wrap_word0", 64'(got_q[0]), 64'hCAFE_0001);
        do_read(32'hFFC, 8'd1, 2'b01, 1'b0, 0, 1'b0);

        // Error cases.
        for (int i = 0; i < 4; i++) begin wbeat_data[i] = $urandom; wbeat_strb[i] = 4'hF; end
        do_write(32'h200, 8'd3, 2'b10, 1'b1, -1, 0, 1'b0);
        do_read(32'h200, 8'd3, 2'b01, 1'b0, 0, 1'b0);
        do_read(32'h200, 8'd3, 2'b10, 1'b1, 0, 1'b0);
        do_write(32'h300, 8'd3, 2'b01, 1'b0, 1, 0, 1'b0);
        do_write(32'h310, 8'd2, 2'b01, 1'b1, -2, 1, 1'b0);
        do_read(32'h300, 8'd7, 2'b01, 1'b0, 0, 1'b0);

        // Randomised traffic.
        for (int t = 0; t < 30; t++) begin
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 1023) << 2) | 32'($urandom_range(0, 3));
            len  = 8'($urandom_range(0, 15));
            r    = int'($urandom_range(0, 7));
            burst = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b01;
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wbeat_data[i] = $urandom; wbeat_strb[i] = 4'($urandom);
                end
                r   = int'($urandom_range(0, 5));
                bad = -1;
                if (r == 0) bad = -2;
                else if (r == 1 && len > 0) bad = int'($urandom_range(0, int'(len) - 1));
                do_write(addr, len, burst, 1'($urandom), bad, int'($urandom_range(0, 3)), 1'b0);
            end else begin
                do_read(addr, len, burst, 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
            end
        end

        // Reset in the middle of a read burst.
        for (int i = 0; i < 8; i++) begin
            cmp_e.data = model_mem[(64 + i) % c_depth];
            cmp_e.resp = 2'b00; cmp_e.last = (i == 7); cmp_e.id = 1'b0;
            r_exp.push_back(cmp_e);
        end
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = 32'h100; arlen = 8'd7; arburst = 2'b01; arid = 1'b0;
        r = 0;
        @(negedge clk);
        while (!arready && r < 50) begin @(negedge clk); r++; end
        check("rst_ar_accept", 64'(arready), 64'd1);
        @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b0; rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_burst", {rvalid, rlast, awready, arready, wready, bvalid}, 64'd0);
        r_exp.delete();
        @(posedge clk); #1 aresetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst_release", {awready, arready, rvalid}, 64'b110);
        do_read(32'h100, 8'd7, 2'b01, 1'b1, 0, 1'b0);

        check("r_queue_drained", 64'(r_exp.size()), 64'd0);
        check("b_queue_drained", 64'(b_exp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
